core_pipe_wb_lsu: RTL

- Writeback-side load/store response unit, directly downstream of the execute-stage LSU.
- Captures the attributes of each data memory transaction when the LSU issues it, then waits for the memory response (dmem_gnt/dmem_err/dmem_rdata).
- Extracts the addressed byte lanes, zero- or sign-extends them, and flags bus errors.
- Holds the result until the register writeback stage accepts it.

---
 rtl/core_pipe_wb_lsu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/core_pipe_wb_lsu.sv
// Writeback-side load/store response unit: captures LSU request attributes, aligns/extends the memory
// response and holds it for writeback. Optional same-cycle bypass: define CORE_WB_LSU_BYPASS_EN.
module core_pipe_wb_lsu #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            e_valid,
    output logic            e_ready,
    input  logic            e_load,
    input  logic            e_store,
    input  logic            e_double,
    input  logic            e_word,
    input  logic            e_half,
    input  logic            e_byte,
    input  logic            e_sext,
    input  logic [2:0]      e_addr_lo,
    input  logic [RD_W-1:0] e_rd,
    input  logic            dmem_gnt,
    input  logic            dmem_err,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_wen,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    output logic            wb_trap_bus
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Captured request attributes; size encodes 0=byte, 1=half, 2=word, 3=double.
    logic            load_reg;
    logic            sext_reg;
    logic [1:0]      size_reg;
    logic [2:0]      addr_lo_reg;
    logic [RD_W-1:0] rd_reg;

    logic            wb_valid_reg;
    logic            wb_wen_reg;
    logic            wb_trap_bus_reg;
    logic [RD_W-1:0] wb_rd_reg;
    logic [XLEN-1:0] wb_wdata_reg;

    logic            accept;
    logic            is_load_in;
    logic [1:0]      size_in;
    logic            resp_fire;
    logic            bypass_fire;

    logic [SHW-1:0]  shift_amt;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] keep_mask;
    logic            sign_bit;
    logic [XLEN-1:0] ext_data;
    logic            form_wen;
    logic            form_trap;
    logic [XLEN-1:0] form_wdata;

    // A request flagged as both load and store is handled as a store.
    assign is_load_in = e_load && !e_store;
    assign accept     = e_valid && e_ready && (e_load || e_store);
    assign resp_fire  = (state_reg == ST_WAIT) && dmem_gnt;

    always_comb begin
        size_in = 2'd0;
        casez ({e_double, e_word, e_half, e_byte})
            4'b1???: size_in = 2'd3;
            4'b01??: size_in = 2'd2;
            4'b001?: size_in = 2'd1;
            default: size_in = 2'd0;
        endcase
    end

    // Doubles are always lane 0, so the low address bits are ignored for them.
    assign shift_amt = (size_reg == 2'd3) ? '0 : SHW'({addr_lo_reg, 3'b000});
    assign lane_data = dmem_rdata >> shift_amt;

    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size_reg)
            2'd0: begin
                keep_mask = {{(XLEN-8){1'b0}}, {8{1'b1}}};
                sign_bit  = lane_data[7];
            end
            2'd1: begin
                keep_mask = {{(XLEN-16){1'b0}}, {16{1'b1}}};
                sign_bit  = lane_data[15];
            end
            2'd2: begin
                keep_mask = {{(XLEN-32){1'b0}}, {32{1'b1}}};
                sign_bit  = lane_data[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
        assign ext_data[gi] = keep_mask[gi] ? lane_data[gi] : (sext_reg & sign_bit);
    end

    assign form_trap  = dmem_err;
    assign form_wen   = load_reg && !dmem_err && (rd_reg != '0);
    assign form_wdata = (load_reg && !dmem_err) ? ext_data : '0;

`ifdef CORE_WB_LSU_BYPASS_EN
    assign bypass_fire = resp_fire && wb_ready;
    assign wb_valid    = wb_valid_reg | bypass_fire;
    assign wb_wen      = bypass_fire ? form_wen   : wb_wen_reg;
    assign wb_rd       = bypass_fire ? rd_reg     : wb_rd_reg;
    assign wb_wdata    = bypass_fire ? form_wdata : wb_wdata_reg;
    assign wb_trap_bus = bypass_fire ? form_trap  : wb_trap_bus_reg;
`else
    assign bypass_fire = 1'b0;
    assign wb_valid    = wb_valid_reg;
    assign wb_wen      = wb_wen_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_wdata    = wb_wdata_reg;
    assign wb_trap_bus = wb_trap_bus_reg;
`endif

    always_comb begin
        e_ready = 1'b0;
        case (state_reg)
            ST_IDLE: e_ready = 1'b1;
            ST_WAIT: e_ready = bypass_fire;
            ST_HOLD: e_ready = wb_ready;
            default: e_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bypass_fire)    state_next = accept ? ST_WAIT : ST_IDLE;
                else if (dmem_gnt)  state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (wb_ready)       state_next = accept ? ST_WAIT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_reg       <= ST_IDLE;
            load_reg        <= 1'b0;
            sext_reg        <= 1'b0;
            size_reg        <= 2'd0;
            addr_lo_reg     <= 3'd0;
            rd_reg          <= '0;
            wb_valid_reg    <= 1'b0;
            wb_wen_reg      <= 1'b0;
            wb_trap_bus_reg <= 1'b0;
            wb_rd_reg       <= '0;
            wb_wdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                load_reg    <= is_load_in;
                sext_reg    <= e_sext;
                size_reg    <= size_in;
                addr_lo_reg <= e_addr_lo;
                rd_reg      <= e_rd;
            end
            // Responses outside WAIT never reach the result registers.
            if (resp_fire && !bypass_fire) begin
                wb_valid_reg    <= 1'b1;
                wb_wen_reg      <= form_wen;
                wb_trap_bus_reg <= form_trap;
                wb_rd_reg       <= rd_reg;
                wb_wdata_reg    <= form_wdata;
            end else if ((state_reg == ST_HOLD) && wb_ready) begin
                wb_valid_reg <= 1'b0;
            end
        end
    end

endmodule
